// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_ZERO_REG   = DEF_NUM_REGS - 1;
  localparam int WCOUNT_WIDTH   = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] regfile_arr_t [DEF_NUM_REGS];
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, hardwired-zero force, optional
// same-cycle write forwarding and pending-bit lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int ZERO_REG   = NUM_REGS - 1,
  parameter int BYPASS     = 1
) (
  input  logic [DATA_WIDTH-1:0] regs_i [NUM_REGS],
  input  logic [NUM_REGS-1:0]   pend_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  pend_o
);
  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

  always_comb begin
    rdata_o = regs_i[raddr_i];
    pend_o  = pend_i[raddr_i];
    if (raddr_i == ZR) begin
      rdata_o = '0;
      pend_o  = 1'b0;
    end else if ((BYPASS != 0) && wen_i && (waddr_i == raddr_i)) begin
      // The forwarded value is the writeback itself, so nothing is awaited.
      rdata_o = wdata_i;
      pend_o  = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending (scoreboard) bit, two read
// ports and a wrapping count of committed writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int ZERO_REG   = NUM_REGS - 1,
  parameter int BYPASS     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    RegWrite,
  input  logic [ADDR_WIDTH-1:0]   WriteRegister,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic                    MarkValid,
  input  logic [ADDR_WIDTH-1:0]   MarkRegister,
  input  logic [ADDR_WIDTH-1:0]   ReadRegister1,
  input  logic [ADDR_WIDTH-1:0]   ReadRegister2,
  output logic [DATA_WIDTH-1:0]   ReadData1,
  output logic [DATA_WIDTH-1:0]   ReadData2,
  output logic                    Pending1,
  output logic                    Pending2,
  output logic [WCOUNT_WIDTH-1:0] WriteCount
);
  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]     pend_q, pend_d;
  logic [WCOUNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                    wr_commit;
  logic                    mk_commit;

  assign wr_commit = RegWrite && (WriteRegister != ZR);
  assign mk_commit = MarkValid && (MarkRegister != ZR);

  // Clear before set: a mark in the same cycle as the writeback belongs to a
  // newer producer and must survive.
  always_comb begin
    pend_d = pend_q;
    if (wr_commit) pend_d[WriteRegister] = 1'b0;
    if (mk_commit) pend_d[MarkRegister] = 1'b1;
    wcnt_d = wr_commit ? wcnt_q + 1'b1 : wcnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
      wcnt_q <= '0;
    end else begin
      if (wr_commit) regs_q[WriteRegister] <= WriteData;
      pend_q <= pend_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign WriteCount = wcnt_q;

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rp1 (
    .regs_i(regs_q), .pend_i(pend_q), .raddr_i(ReadRegister1),
    .wen_i(RegWrite), .waddr_i(WriteRegister), .wdata_i(WriteData),
    .rdata_o(ReadData1), .pend_o(Pending1)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rp2 (
    .regs_i(regs_q), .pend_i(pend_q), .raddr_i(ReadRegister2),
    .wen_i(RegWrite), .waddr_i(WriteRegister), .wdata_i(WriteData),
    .rdata_o(ReadData2), .pend_o(Pending2)
  );
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter: DATA_WIDTH, 64, bits per register.
REQ-003 Parameter: NUM_REGS, 32, register count (power of two, at least 4).
REQ-004 Parameter: ADDR_WIDTH, $clog2(NUM_REGS), register index width.
REQ-005 Parameter: ZERO_REG, NUM_REGS-1, index of the hardwired-zero register.
REQ-006 Parameter: BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-007 Port: clk  in  1  rising-edge clock.
REQ-008 Port: reset  in  1  synchronous active-high reset.
REQ-009 Port: RegWrite  in  1  write enable.
REQ-010 Port: WriteRegister  in  ADDR_WIDTH  write index.
REQ-011 Port: WriteData  in  DATA_WIDTH  write data.
REQ-012 Port: MarkValid  in  1  request to set the pending bit of MarkRegister.
REQ-013 Port: MarkRegister  in  ADDR_WIDTH  register being claimed by an in-flight producer.
REQ-014 Port: ReadRegister1, ReadRegister2  in  ADDR_WIDTH each  read indices.
REQ-015 Port: ReadData1, ReadData2  out  DATA_WIDTH each  read data.
REQ-016 Port: Pending1, Pending2  out  1 each  1 = the read register awaits a writeback.
REQ-017 Port: WriteCount  out  16  count of committed writes.

Function
REQ-018 A write SHALL commit at the rising clk edge where RegWrite=1 and WriteRegister!=ZERO_REG; all other writes SHALL be discarded.
REQ-019 Read ports SHALL be combinational: ReadData is the stored value of ReadRegister in the same cycle.
REQ-020 Reading ZERO_REG SHALL return all-zero data and Pending=0, regardless of any write or mark.
REQ-021 With BYPASS=1, if RegWrite=1, WriteRegister==ReadRegisterN and the index is not ZERO_REG, ReadDataN SHALL equal WriteData and PendingN SHALL be 0 in that cycle.
REQ-022 With BYPASS=0, reads SHALL return the pre-edge stored value and pre-edge pending bit.
REQ-023 A committed write SHALL clear the pending bit of WriteRegister at the same edge.
REQ-024 MarkValid=1 with MarkRegister!=ZERO_REG SHALL set that pending bit at the edge; marks to ZERO_REG SHALL be ignored.
REQ-025 A mark and a write to the same register in the same cycle SHALL commit the data and leave the pending bit set (the newer producer wins).
REQ-026 A mark of an already-pending register SHALL leave it pending; a write to a non-pending register SHALL commit normally.
REQ-027 WriteCount SHALL increment by 1 per committed write, wrap from 0xFFFF to 0x0000, and not count discarded writes.
REQ-028 Both read ports SHALL be fully independent and may address the same register.

Reset
REQ-029 reset=1 at a rising edge SHALL clear every register to 0, every pending bit to 0 and WriteCount to 0; reset SHALL take priority over write and mark.
REQ-030 During reset, outputs SHALL follow REQ-019 to REQ-022 from the cleared state one edge after reset is asserted.

Structure
REQ-031 Package regfile_pkg SHALL hold the default DATA_WIDTH, NUM_REGS and ZERO_REG constants and the register-array typedef.
REQ-032 One sub-module, regfile_read_port (index mux, zero-register force, bypass, pending lookup), SHALL be instantiated twice.
REQ-033 Storage SHALL be one DATA_WIDTH x NUM_REGS flop array plus a NUM_REGS-bit pending vector, with no latches.

Verification
REQ-034 Reset, then read all indices -> all data 0, all Pending 0, WriteCount 0.
REQ-035 Write 0xDEADBEEF_00000001 to reg 5, read reg 5 in the next cycle -> that value; read reg 5 in the same cycle -> that value if BYPASS=1, 0 if BYPASS=0.
REQ-036 Write 0xFFFF...F to reg 31 (ZERO_REG) -> reads of reg 31 stay 0, WriteCount unchanged.
REQ-037 Mark reg 3 -> Pending=1 next cycle; write reg 3 -> Pending=0 after the edge; mark and write reg 3 in the same cycle -> data updated, Pending=1.
REQ-038 Perform 65536 committed writes -> WriteCount wraps to 0; assert reset mid-sequence with a simultaneous write and mark -> all state 0 after the edge.
